// File: rtl/fb_rect_fill.sv
// fb_rect_fill: rectangle fill engine feeding the framebuffer write port.
//
// A command (x0, y0, width, height, color) is accepted on a start strobe while
// idle. The rectangle is clipped to the H_RES x V_RES screen. The engine then
// streams one write per clock in raster order and pulses done for one cycle.
// An empty or fully off-screen command produces only the done pulse.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   start    in   command strobe, sampled only while idle
//   x0, y0   in   rectangle origin (left column, top row)
//   width    in   rectangle width in pixels
//   height   in   rectangle height in lines
//   color    in   fill colour
//   busy     out  high while writes are being streamed
//   done     out  one-cycle completion pulse
//   wr_en    out  framebuffer write enable
//   wr_addr  out  framebuffer address, y*H_RES + x
//   wr_data  out  framebuffer write data
module fb_rect_fill #(
    parameter int unsigned H_RES   = 320,
    parameter int unsigned V_RES   = 240,
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned COLOR_W = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [8:0]         x0,
    input  logic [7:0]         y0,
    input  logic [8:0]         width,
    input  logic [7:0]         height,
    input  logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               done,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data
);

    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

    state_e            state_q;
    // x_q/y_q/row_base_q describe the pixel currently presented on wr_addr.
    logic [8:0]        x_q;
    logic [7:0]        y_q;
    logic [8:0]        x0_q;
    logic [8:0]        x_last_q;
    logic [7:0]        y_last_q;
    logic [ADDR_W-1:0] row_base_q;

    logic [9:0]        x_sum;
    logic [9:0]        y_sum;
    logic [9:0]        x_end;
    logic [9:0]        y_end;
    logic              cmd_empty;
    logic [ADDR_W-1:0] start_row_base;
    logic [ADDR_W-1:0] next_row_base;
    logic              x_at_end;
    logic              y_at_end;

    always_comb begin
        // 10-bit sums cannot overflow for 9-bit and 8-bit operands.
        x_sum          = {1'b0, x0} + {1'b0, width};
        y_sum          = {2'b00, y0} + {2'b00, height};
        x_end          = (x_sum > 10'(H_RES)) ? 10'(H_RES) : x_sum;
        y_end          = (y_sum > 10'(V_RES)) ? 10'(V_RES) : y_sum;
        cmd_empty      = (width == 9'd0) || (height == 8'd0) ||
                         ({1'b0, x0} >= 10'(H_RES)) || ({2'b00, y0} >= 10'(V_RES));
        // Only multiply in the design; evaluated once per command.
        start_row_base = ADDR_W'(y0) * ADDR_W'(H_RES);
        next_row_base  = row_base_q + ADDR_W'(H_RES);
        x_at_end       = (x_q == x_last_q);
        y_at_end       = (y_q == y_last_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            x0_q       <= '0;
            x_last_q   <= '0;
            y_last_q   <= '0;
            row_base_q <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    wr_en <= 1'b0;
                    if (start) begin
                        if (cmd_empty) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            // First pixel goes out on the very next cycle.
                            state_q    <= StFill;
                            busy       <= 1'b1;
                            wr_en      <= 1'b1;
                            wr_data    <= color;
                            wr_addr    <= start_row_base + ADDR_W'(x0);
                            x_q        <= x0;
                            y_q        <= y0;
                            x0_q       <= x0;
                            // Non-empty guarantees x_end > x0 and y_end > y0.
                            x_last_q   <= 9'(x_end - 10'd1);
                            y_last_q   <= 8'(y_end - 10'd1);
                            row_base_q <= start_row_base;
                        end
                    end
                end
                StFill: begin
                    if (x_at_end && y_at_end) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        wr_en   <= 1'b0;
                        done    <= 1'b1;
                    end else if (x_at_end) begin
                        x_q        <= x0_q;
                        y_q        <= y_q + 8'd1;
                        row_base_q <= next_row_base;
                        wr_addr    <= next_row_base + ADDR_W'(x0_q);
                    end else begin
                        x_q     <= x_q + 9'd1;
                        wr_addr <= wr_addr + ADDR_W'(1);
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Bench for fb_rect_fill: stimulus pushes the expected write/done events (with
// the cycle each must appear in) into a queue; a monitor pops and compares.
module tb_fb_rect_fill;

    localparam int H = 320;
    localparam int V = 240;

    logic        clock;
    logic        reset;
    logic        start;
    logic [8:0]  x0;
    logic [7:0]  y0;
    logic [8:0]  width;
    logic [7:0]  height;
    logic [2:0]  color;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [2:0]  wr_data;

    fb_rect_fill #(
        .H_RES  (320),
        .V_RES  (240),
        .ADDR_W (17),
        .COLOR_W(3)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .x0     (x0),
        .y0     (y0),
        .width  (width),
        .height (height),
        .color  (color),
        .busy   (busy),
        .done   (done),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    typedef struct {
        bit is_done;
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_cmp;
    int   n_bad;
    int   last_addr;
    int   last_data;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: enumerate the clipped rectangle in raster order.
    // Write k (1-based) is due at cycle c+k, done at c+P+1. Only the first
    // max_k writes are queued; done is queued only if all writes are.
    task automatic push_model(input int ax0, input int ay0, input int aw, input int ah,
                              input int acol, input int c, input int max_k,
                              output int p);
        int   xe;
        int   ye;
        int   k;
        exp_t r;
        xe = (ax0 + aw < H) ? ax0 + aw : H;
        ye = (ay0 + ah < V) ? ay0 + ah : V;
        p  = (xe > ax0 && ye > ay0) ? (xe - ax0) * (ye - ay0) : 0;
        k  = 0;
        for (int yy = ay0; yy < ye; yy++) begin
            for (int xx = ax0; xx < xe; xx++) begin
                k++;
                if (k <= max_k) begin
                    r.is_done = 1'b0;
                    r.addr    = yy * H + xx;
                    r.data    = acol;
                    r.cyc     = c + k;
                    exp_q.push_back(r);
                end
            end
        end
        if (p <= max_k) begin
            r.is_done = 1'b1;
            r.addr    = 0;
            r.data    = 0;
            r.cyc     = c + p + 1;
            exp_q.push_back(r);
        end
    endtask

    task automatic drive(input int ax0, input int ay0, input int aw, input int ah,
                         input int acol);
        x0     = 9'(ax0);
        y0     = 8'(ay0);
        width  = 9'(aw);
        height = 8'(ah);
        color  = 3'(acol);
        start  = 1'b1;
    endtask

    // Issue one command; optionally fire stray starts during FILL and DONE.
    task automatic run_cmd(input int ax0, input int ay0, input int aw, input int ah,
                           input int acol, input bit inj_busy, input bit inj_done);
        int c;
        int p;
        @(negedge clock);
        c = cyc;
        drive(ax0, ay0, aw, ah, acol);
        push_model(ax0, ay0, aw, ah, acol, c, 1 << 30, p);
        @(negedge clock);
        start = 1'b0;
        if (inj_busy && p >= 2) drive(0, 0, 5, 5, 7);
        while (cyc < c + p + 1) begin
            @(negedge clock);
            start = 1'b0;
        end
        if (inj_done) begin
            drive(0, 0, 5, 5, 7);
            @(negedge clock);
            start = 1'b0;
        end
    endtask

    task automatic monitor();
        exp_t r;
        bit   ok;
        forever begin
            @(negedge clock);
            if (reset) begin
                last_addr = 0;
                last_data = 0;
                if (wr_en || done || busy) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL reset_outputs: wr_en=%0b done=%0b busy=%0b, required all 0",
                             wr_en, done, busy);
                end
            end else if (wr_en || done || busy) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_output cycle %0d: wr_en=%0b done=%0b busy=%0b addr=%0d, required no activity",
                             cyc, wr_en, done, busy, wr_addr);
                end else begin
                    r = exp_q.pop_front();
                    if (r.is_done)
                        ok = done && !wr_en && !busy && int'(wr_addr) == last_addr &&
                             int'(wr_data) == last_data;
                    else
                        ok = wr_en && busy && !done && int'(wr_addr) == r.addr &&
                             int'(wr_data) == r.data;
                    ok = ok && (cyc == r.cyc);
                    if (!ok) begin
                        n_bad++;
                        $display("FAIL %s cycle %0d: wr_en=%0b done=%0b busy=%0b addr=%0d data=%0d; required cycle %0d addr=%0d data=%0d",
                                 r.is_done ? "done_event" : "write_event", cyc, wr_en, done,
                                 busy, wr_addr, wr_data, r.cyc,
                                 r.is_done ? last_addr : r.addr,
                                 r.is_done ? last_data : r.data);
                    end
                    if (!r.is_done) begin
                        last_addr = r.addr;
                        last_data = r.data;
                    end
                end
            end
        end
    endtask

    initial begin
        int c;
        int p;
        int sel;
        int ax0;
        int ay0;
        n_cmp     = 0;
        n_bad     = 0;
        last_addr = 0;
        last_data = 0;
        reset     = 1'b1;
        start     = 1'b0;
        x0        = '0;
        y0        = '0;
        width     = '0;
        height    = '0;
        color     = '0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clock);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_wr_en", int'(wr_en), 0);
        chk("reset_wr_addr", int'(wr_addr), 0);
        chk("reset_wr_data", int'(wr_data), 0);
        reset = 1'b0;
        @(negedge clock);

        // Basic 2x2 fill, then clipping at the bottom-right corner.
        run_cmd(10, 5, 2, 2, 5, 1'b0, 1'b0);
        run_cmd(318, 239, 5, 3, 3, 1'b0, 1'b0);
        // Empty commands.
        run_cmd(10, 5, 0, 4, 6, 1'b0, 1'b0);
        run_cmd(320, 5, 1, 1, 6, 1'b0, 1'b0);
        run_cmd(10, 240, 1, 1, 6, 1'b0, 1'b0);
        // Stray starts during FILL and DONE are ignored.
        run_cmd(10, 5, 2, 2, 5, 1'b1, 1'b1);

        // Reset during the third write of the 2x2 fill.
        @(negedge clock);
        c = cyc;
        drive(10, 5, 2, 2, 5);
        push_model(10, 5, 2, 2, 5, c, 3, p);
        @(negedge clock);
        start = 1'b0;
        while (cyc < c + 3) @(negedge clock);
        #1 reset = 1'b1;
        #1;
        chk("async_wr_en", int'(wr_en), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        chk("async_wr_addr", int'(wr_addr), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        chk("post_reset_queue", exp_q.size(), 0);
        run_cmd(10, 5, 2, 2, 5, 1'b0, 1'b0);

        // Randomized commands, biased toward the screen edges.
        for (int i = 0; i < 16; i++) begin
            sel = $urandom_range(0, 2);
            ax0 = (sel == 0) ? $urandom_range(0, 300) :
                  (sel == 1) ? $urandom_range(290, 330) : $urandom_range(0, 511);
            sel = $urandom_range(0, 2);
            ay0 = (sel == 0) ? $urandom_range(0, 230) :
                  (sel == 1) ? $urandom_range(225, 245) : $urandom_range(0, 255);
            run_cmd(ax0, ay0, $urandom_range(0, 24), $urandom_range(0, 12),
                    $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Full-screen clear.
        run_cmd(0, 0, 320, 240, 0, 1'b0, 1'b0);

        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clock);
        while (exp_q.size() != 0) begin
            exp_t r;
            r = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_event: expected %s addr=%0d at cycle %0d, got nothing",
                     r.is_done ? "done" : "write", r.addr, r.cyc);
        end
        repeat (4) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
